// File: rtl/cdb_arbiter_pkg.sv
// Shared types and default widths for the common-data-bus arbiter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package cdb_arbiter_pkg;

    localparam int DEF_UNITS         = 4;
    localparam int DEF_OPERAND_WIDTH = 32;
    localparam int DEF_RS_ID_WIDTH   = 5;

    // One broadcast on the common data bus at the default widths.
    typedef struct packed {
        logic                         valid;
        logic [DEF_RS_ID_WIDTH-1:0]   rs_id;
        logic [DEF_OPERAND_WIDTH-1:0] value;
    } cdb_t;

    // Successor of idx in a ring of n slots.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundles the execution-unit result handshakes and the CDB broadcast bus.
// Latency: n/a (wiring only).
// Backpressure: units hold result_valid/payload until result_ready; the CDB has none.
//
// master: execution-unit side (drives results, observes ready and broadcast)
// slave : arbiter side (consumes results, drives ready and broadcast)
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int UNITS         = DEF_UNITS,
    parameter int OPERAND_WIDTH = DEF_OPERAND_WIDTH,
    parameter int RS_ID_WIDTH   = DEF_RS_ID_WIDTH
);
    logic [UNITS-1:0]                    result_valid;
    logic [UNITS-1:0]                    result_ready;
    logic [UNITS-1:0][RS_ID_WIDTH-1:0]   result_rs_id;
    logic [UNITS-1:0][OPERAND_WIDTH-1:0] result_value;

    logic                                cdb_valid;
    logic [RS_ID_WIDTH-1:0]              cdb_rs_id;
    logic [OPERAND_WIDTH-1:0]            cdb_value;

    modport master (
        output result_valid, result_rs_id, result_value,
        input  result_ready, cdb_valid, cdb_rs_id, cdb_value
    );

    modport slave (
        input  result_valid, result_rs_id, result_value,
        output result_ready, cdb_valid, cdb_rs_id, cdb_value
    );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first requester at or after ptr.
// Latency: grant is combinational from req_i; ptr updates on the next rising edge.
// Backpressure: ptr only moves when advance_i confirms the grant was taken.
//
// Ports: clk_i, rst_ni (sync, active-low), req_i[N], advance_i,
//        grant_o[N] (one-hot), grant_idx_o (binary index), grant_vld_o (any grant).
module rr_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N  = DEF_UNITS,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] grant_idx_o,
    output logic          grant_vld_o
);

    logic [PW-1:0] ptr_q, ptr_d;
    int            idx;

    // Scan ptr, ptr+1, ... and stop at the first request.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!grant_vld_o && req_i[idx]) begin
                grant_vld_o  = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = PW'(idx);
            end
        end
    end

    // The granted unit drops to lowest priority; no grant means ptr holds.
    // With N=1 rr_next always yields 0, so ptr stays fixed.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && grant_vld_o) begin
            ptr_d = PW'(rr_next(int'(grant_idx_o), N));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Arbitrates finished execution-unit results onto the single common data bus.
// Latency: grant/ready combinational; broadcast registered one cycle after acceptance.
// Backpressure: one result accepted per cycle; flush or reset withholds all ready; CDB never stalls.
//
// Ports: clk, rst (sync, active-low), flush, bus (cdb_arbiter_if.slave:
//        result_valid/ready/rs_id/value per unit, cdb_valid/rs_id/value),
//        grant_count (accepted results since reset, wraps at 16 bits).
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int UNITS         = DEF_UNITS,
    parameter int OPERAND_WIDTH = DEF_OPERAND_WIDTH,
    parameter int RS_ID_WIDTH   = DEF_RS_ID_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    cdb_arbiter_if.slave       bus,
    output logic [15:0]        grant_count
);

    localparam int PW = (UNITS > 1) ? $clog2(UNITS) : 1;

    logic [UNITS-1:0]         grant;
    logic [PW-1:0]            grant_idx;
    logic                     grant_vld;
    logic                     accept;

    logic                     cdb_valid_q, cdb_valid_d;
    logic [RS_ID_WIDTH-1:0]   cdb_rs_id_q, cdb_rs_id_d;
    logic [OPERAND_WIDTH-1:0] cdb_value_q, cdb_value_d;
    logic [15:0]              grant_count_q, grant_count_d;

    rr_arbiter #(
        .N  (UNITS),
        .PW (PW)
    ) u_rr (
        .clk_i       (clk),
        .rst_ni      (rst),
        .req_i       (bus.result_valid),
        .advance_i   (accept),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .grant_vld_o (grant_vld)
    );

    // A grant is only a real acceptance outside flush and reset; the
    // pointer and counter follow acceptance, not the raw grant.
    assign accept           = grant_vld & ~flush & rst;
    assign bus.result_ready = accept ? grant : '0;

    always_comb begin
        cdb_valid_d   = accept;
        cdb_rs_id_d   = cdb_rs_id_q;
        cdb_value_d   = cdb_value_q;
        grant_count_d = grant_count_q;
        if (accept) begin
            cdb_rs_id_d   = bus.result_rs_id[grant_idx];
            cdb_value_d   = bus.result_value[grant_idx];
            grant_count_d = grant_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cdb_valid_q   <= 1'b0;
            cdb_rs_id_q   <= '0;
            cdb_value_q   <= '0;
            grant_count_q <= '0;
        end else begin
            cdb_valid_q   <= cdb_valid_d;
            cdb_rs_id_q   <= cdb_rs_id_d;
            cdb_value_q   <= cdb_value_d;
            grant_count_q <= grant_count_d;
        end
    end

    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_rs_id = cdb_rs_id_q;
    assign bus.cdb_value = cdb_value_q;
    assign grant_count   = grant_count_q;

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter UNITS, default 4, number of execution units that share the common data bus (CDB).
REQ-002 Parameter OPERAND_WIDTH, default 32, result value width.
REQ-003 Parameter RS_ID_WIDTH, default 5, reservation-station ID width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low.
REQ-006 flush  input  1  pipeline flush; drops pending and outgoing broadcasts.
REQ-007 result_valid[0:UNITS-1]  input  1 each  unit i holds a finished result.
REQ-008 result_ready[0:UNITS-1]  output  1 each  unit i's result is accepted this cycle.
REQ-009 result_rs_id[0:UNITS-1]  input  RS_ID_WIDTH each  producing reservation-station ID.
REQ-010 result_value[0:UNITS-1]  input  OPERAND_WIDTH each  result value.
REQ-011 cdb_valid  output  1  broadcast valid; drives the reservation stations' operand_valid lines.
REQ-012 cdb_rs_id  output  RS_ID_WIDTH  broadcast tag; drives update_op_rs_id_in.
REQ-013 cdb_value  output  OPERAND_WIDTH  broadcast value; drives update_op_value_in.
REQ-014 grant_count  output  16  number of accepted results since reset, wrapping.

Function
REQ-015 The block SHALL grant at most one unit per cycle: result_ready[i]=1 only for the granted unit, and only while result_valid[i]=1 and flush=0.
REQ-016 Grant SHALL be combinational, round-robin: scan i = ptr, ptr+1, ... modulo UNITS and grant the first unit with result_valid=1.
REQ-017 Priority pointer ptr SHALL update on an accepted grant only, to (granted index + 1) mod UNITS; it SHALL hold when there is no grant.
REQ-018 Accepted result SHALL appear on cdb_valid/cdb_rs_id/cdb_value exactly one cycle after acceptance (registered output).
REQ-019 cdb_valid SHALL be a one-cycle pulse per accepted result; with no grant in cycle N, cdb_valid=0 in cycle N+1.
REQ-020 cdb_rs_id/cdb_value SHALL hold their last value while cdb_valid=0.
REQ-021 The CDB has no backpressure; back-to-back grants SHALL produce back-to-back broadcasts at full rate (one per cycle).
REQ-022 A unit SHALL keep result_valid and its payload stable until result_ready; the arbiter SHALL NOT require result_valid to be deasserted between results.
REQ-023 flush=1 SHALL force all result_ready=0 that cycle and cdb_valid=0 the next cycle; ptr holds; grant_count does not increment.
REQ-024 grant_count SHALL increment by 1 per accepted grant and wrap from 0xFFFF to 0x0000.
REQ-025 With only one requester, that unit SHALL be granted every cycle it is valid, regardless of ptr.
REQ-026 UNITS=1 SHALL degenerate to a registered pass-through with ptr fixed at 0.

Reset
REQ-027 On rst=0 at a rising edge: cdb_valid=0, cdb_rs_id=0, cdb_value=0, ptr=0, grant_count=0.
REQ-028 During reset, all result_ready SHALL be 0.
REQ-029 Reset asserted mid-broadcast SHALL drop that broadcast: cdb_valid=0 the cycle after the reset edge.

Structure
REQ-030 A cdb_t packed struct {valid, rs_id, value} and the default widths SHALL live in ppc_types; cdb_value/cdb_rs_id/cdb_valid MAY be exported as one cdb_t.
REQ-031 The round-robin search and pointer SHALL be a sub-module rr_arbiter (parameter N; inputs req[N], advance; output one-hot grant), reusable for dispatch arbitration.
REQ-032 The payload multiplexer and output register SHALL stay in cdb_arbiter.

Verification
REQ-033 Reset, then unit 2 valid with rs_id=5, value=0xDEADBEEF -> result_ready[2]=1 same cycle; next cycle cdb_valid=1, cdb_rs_id=5, cdb_value=0xDEADBEEF; ptr=3.
REQ-034 All 4 units valid continuously from reset -> grants 0,1,2,3,0 on five consecutive cycles; cdb_valid high for five consecutive cycles; grant_count=5.
REQ-035 ptr=3, units 1 and 3 valid -> unit 3 granted first, unit 1 next cycle, ptr ends at 2.
REQ-036 Units 0 and 1 valid with flush=1 for one cycle -> no result_ready, cdb_valid=0 next cycle, grant_count unchanged; unit 0 granted the cycle after flush drops.
REQ-037 Grant in cycle N, rst=0 at edge N+1 -> cdb_valid=0, outputs zero, grant_count=0, ptr=0.
REQ-038 Force grant_count to 0xFFFF via 65535 grants, then one more grant -> grant_count=0x0000.
